// File: rtl/axi_mem_slave.sv
// AXI4 memory slave: 2^ADDR_BITS words of 64 bits, INCR-only bursts,
// with independent write (IDLE/DATA/RESP) and read (IDLE/DATA) engines.
module axi_mem_slave #(
   parameter int unsigned ADDR_BITS = 9
) (
   input  logic        S_AXI_ACLK,
   input  logic        S_AXI_ARESET,
   input  logic [31:0] S_AXI_AWADDR,
   input  logic [7:0]  S_AXI_AWLEN,
   input  logic [2:0]  S_AXI_AWSIZE,
   input  logic [1:0]  S_AXI_AWBURST,
   input  logic [2:0]  S_AXI_AWPROT,
   input  logic        S_AXI_AWVALID,
   output logic        S_AXI_AWREADY,
   input  logic [63:0] S_AXI_WDATA,
   input  logic [7:0]  S_AXI_WSTRB,
   input  logic        S_AXI_WLAST,
   input  logic        S_AXI_WVALID,
   output logic        S_AXI_WREADY,
   output logic [1:0]  S_AXI_BRESP,
   output logic        S_AXI_BVALID,
   input  logic        S_AXI_BREADY,
   input  logic [31:0] S_AXI_ARADDR,
   input  logic [7:0]  S_AXI_ARLEN,
   input  logic [2:0]  S_AXI_ARSIZE,
   input  logic [1:0]  S_AXI_ARBURST,
   input  logic [2:0]  S_AXI_ARPROT,
   input  logic        S_AXI_ARVALID,
   output logic        S_AXI_ARREADY,
   output logic [63:0] S_AXI_RDATA,
   output logic [1:0]  S_AXI_RRESP,
   output logic        S_AXI_RLAST,
   output logic        S_AXI_RVALID,
   input  logic        S_AXI_RREADY
);
   localparam int unsigned DEPTH = 2 ** ADDR_BITS;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
   typedef enum logic       {R_IDLE, R_DATA} rstate_e;

   wstate_e wstate_q, wstate_d;
   rstate_e rstate_q, rstate_d;

   logic [63:0]          mem_q [DEPTH];
   logic [ADDR_BITS-1:0] widx_q, ridx_q, ridx_next;
   logic [7:0]           rleft_q;
   logic [63:0]          rdata_q;
   logic                 rlast_q;
   logic                 aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic                 unused_ok;

   assign aw_hs     = S_AXI_AWVALID & S_AXI_AWREADY;
   assign w_hs      = S_AXI_WVALID  & S_AXI_WREADY;
   assign b_hs      = S_AXI_BVALID  & S_AXI_BREADY;
   assign ar_hs     = S_AXI_ARVALID & S_AXI_ARREADY;
   assign r_hs      = S_AXI_RVALID  & S_AXI_RREADY;
   assign ridx_next = ridx_q + 1'b1;

   assign S_AXI_BRESP = 2'b00;
   assign S_AXI_RRESP = 2'b00;

   assign unused_ok = ^{S_AXI_AWADDR[31:ADDR_BITS+3], S_AXI_AWADDR[2:0], S_AXI_AWLEN,
                        S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWPROT,
                        S_AXI_ARADDR[31:ADDR_BITS+3], S_AXI_ARADDR[2:0],
                        S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARPROT};

   // ---------------- write engine ----------------
   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) wstate_q <= W_IDLE;
      else              wstate_q <= wstate_d;
   end

   always_comb begin
      wstate_d = wstate_q;
      unique case (wstate_q)
         W_IDLE: if (aw_hs)               wstate_d = W_DATA;
         W_DATA: if (w_hs && S_AXI_WLAST) wstate_d = W_RESP;
         W_RESP: if (b_hs)                wstate_d = W_IDLE;
         default:                         wstate_d = W_IDLE;
      endcase
   end

   // Handshake outputs are masked by reset so they read 0 throughout reset.
   always_comb begin
      S_AXI_AWREADY = 1'b0;
      S_AXI_WREADY  = 1'b0;
      S_AXI_BVALID  = 1'b0;
      if (!S_AXI_ARESET) begin
         S_AXI_AWREADY = (wstate_q == W_IDLE);
         S_AXI_WREADY  = (wstate_q == W_DATA);
         S_AXI_BVALID  = (wstate_q == W_RESP);
      end
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET)  widx_q <= '0;
      else if (aw_hs)    widx_q <= S_AXI_AWADDR[ADDR_BITS+2:3];
      else if (w_hs)     widx_q <= widx_q + 1'b1;
   end

   // Storage is never reset; contents survive S_AXI_ARESET.
   always_ff @(posedge S_AXI_ACLK) begin
      if (w_hs) begin
         for (int unsigned i = 0; i < 8; i++) begin
            if (S_AXI_WSTRB[i]) mem_q[widx_q][8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
         end
      end
   end

   // ---------------- read engine ----------------
   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) rstate_q <= R_IDLE;
      else              rstate_q <= rstate_d;
   end

   always_comb begin
      rstate_d = rstate_q;
      unique case (rstate_q)
         R_IDLE: if (ar_hs)           rstate_d = R_DATA;
         R_DATA: if (r_hs && rlast_q) rstate_d = R_IDLE;
         default:                     rstate_d = R_IDLE;
      endcase
   end

   always_comb begin
      S_AXI_ARREADY = 1'b0;
      S_AXI_RVALID  = 1'b0;
      S_AXI_RLAST   = 1'b0;
      S_AXI_RDATA   = '0;
      if (!S_AXI_ARESET) begin
         S_AXI_ARREADY = (rstate_q == R_IDLE);
         S_AXI_RVALID  = (rstate_q == R_DATA);
         S_AXI_RLAST   = rlast_q;
         S_AXI_RDATA   = rdata_q;
      end
   end

   // Next beat is fetched on the accepting handshake, so a same-cycle write sees old data.
   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         ridx_q  <= '0;
         rleft_q <= '0;
         rdata_q <= '0;
         rlast_q <= 1'b0;
      end else if (ar_hs) begin
         ridx_q  <= S_AXI_ARADDR[ADDR_BITS+2:3];
         rleft_q <= S_AXI_ARLEN;
         rdata_q <= mem_q[S_AXI_ARADDR[ADDR_BITS+2:3]];
         rlast_q <= (S_AXI_ARLEN == 8'd0);
      end else if (r_hs && !rlast_q) begin
         ridx_q  <= ridx_next;
         rleft_q <= rleft_q - 8'd1;
         rdata_q <= mem_q[ridx_next];
         rlast_q <= (rleft_q == 8'd1);
      end else if (r_hs) begin
         rlast_q <= 1'b0;
      end
   end
endmodule

// File: tb/tb_axi_mem_slave.sv
// Randomised bench for axi_mem_slave against a flat word-array memory model.
module tb_axi_mem_slave;
   localparam int unsigned AB    = 9;
   localparam int unsigned DEPTH = 2 ** AB;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] awaddr, araddr;
   logic [7:0]  awlen, arlen, wstrb;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rlast, rvalid, rready;
   logic [63:0] wdata, rdata;
   logic [1:0]  bresp, rresp;

   logic [63:0] mref [DEPTH];
   logic [63:0] wdat [256];
   logic [7:0]  wstb [256];
   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   axi_mem_slave #(.ADDR_BITS(AB)) dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(3'd3),
      .S_AXI_AWBURST(2'b01), .S_AXI_AWPROT(3'd0), .S_AXI_AWVALID(awvalid),
      .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
      .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(3'd3),
      .S_AXI_ARBURST(2'b01), .S_AXI_ARPROT(3'd0), .S_AXI_ARVALID(arvalid),
      .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
      .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int unsigned word_of(input logic [31:0] addr);
      return (addr >> 3) % DEPTH;
   endfunction

   // Write burst of len+1 beats from wdat/wstb; gaps inserts random WVALID-low cycles.
   task automatic axi_write(input logic [31:0] addr, input int unsigned len, input bit gaps);
      int unsigned idx;
      idx = word_of(addr);
      @(negedge clk);
      awaddr = addr; awlen = len[7:0]; awvalid = 1'b1;
      wvalid = 1'b1; wdata = {$urandom, $urandom}; wstrb = 8'hFF; wlast = 1'b1;
      check_eq("awready_idle", awready, 1);
      check_eq("wready_idle", wready, 0);
      @(negedge clk);
      awvalid = 1'b0;
      for (int unsigned b = 0; b <= len; b++) begin
         if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
               wvalid = 1'b0;
               @(negedge clk);
               check_eq("wready_gap", wready, 1);
            end
         end
         wvalid = 1'b1; wdata = wdat[b]; wstrb = wstb[b]; wlast = (b == len);
         check_eq("wready_data", wready, 1);
         check_eq("awready_data", awready, 0);
         @(negedge clk);
         for (int unsigned i = 0; i < 8; i++)
            if (wstb[b][i]) mref[idx][8*i +: 8] = wdat[b][8*i +: 8];
         idx = (idx + 1) % DEPTH;
      end
      wvalid = 1'b0; wlast = 1'b0;
      check_eq("bvalid", bvalid, 1);
      check_eq("bresp", bresp, 0);
      repeat ($urandom_range(0, 2)) begin
         @(negedge clk);
         check_eq("bvalid_hold", bvalid, 1);
      end
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      check_eq("bvalid_clr", bvalid, 0);
      check_eq("awready_ret", awready, 1);
   endtask

   // mode 0: RREADY always 1; mode 1: 1,0,1,0...; mode 2: random.
   task automatic axi_read(input logic [31:0] addr, input int unsigned len, input int unsigned mode);
      logic [63:0] exp [256];
      int unsigned idx, b, cyc;
      bit rr;
      idx = word_of(addr);
      for (int unsigned k = 0; k <= len; k++) exp[k] = mref[(idx + k) % DEPTH];
      @(negedge clk);
      araddr = addr; arlen = len[7:0]; arvalid = 1'b1;
      check_eq("arready_idle", arready, 1);
      check_eq("rvalid_idle", rvalid, 0);
      @(negedge clk);
      arvalid = 1'b0;
      b = 0; cyc = 0;
      while (b <= len && cyc < 2000) begin
         rr = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
         rready = rr;
         check_eq("rvalid", rvalid, 1);
         check_eq("rdata", rdata, exp[b]);
         check_eq("rlast", rlast, (b == len));
         check_eq("rresp", rresp, 0);
         check_eq("arready_busy", arready, 0);
         @(negedge clk);
         if (rr) b++;
         cyc++;
      end
      rready = 1'b0;
      check_eq("rd_done", (b > len), 1);
      if (mode == 0) check_eq("rd_nostall", cyc, len + 1);
      check_eq("rvalid_end", rvalid, 0);
      check_eq("arready_end", arready, 1);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      awaddr = '0; awlen = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0;
      wvalid = 1'b0; bready = 1'b0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_awready", awready, 0);
      check_eq("rst_arready", arready, 0);
      check_eq("rst_rvalid", rvalid, 0);
      check_eq("rst_bvalid", bvalid, 0);
      rst = 1'b0;
      #1;
      check_eq("post_rst_awready", awready, 1);
      check_eq("post_rst_arready", arready, 1);

      // fill all memory so the model is fully defined
      for (int unsigned h = 0; h < 2; h++) begin
         for (int unsigned k = 0; k < 256; k++) begin
            wdat[k] = {$urandom, $urandom};
            wstb[k] = 8'hFF;
         end
         axi_write(h * 2048, 255, 1'b0);
      end

      // single write/read
      wdat[0] = 64'h1122334455667788; wstb[0] = 8'hFF;
      axi_write(32'h10, 0, 1'b0);
      axi_read(32'h10, 0, 0);

      // byte strobes
      wdat[0] = '1; wstb[0] = 8'hFF;
      axi_write(32'h20, 0, 1'b0);
      wdat[0] = '0; wstb[0] = 8'h0C;
      axi_write(32'h20, 0, 1'b0);
      axi_read(32'h20, 0, 0);
      check_eq("strobe_word", mref[4], 64'hFFFF_FFFF_0000_FFFF);

      // 4-beat burst, read back with toggling RREADY
      for (int unsigned k = 0; k < 4; k++) begin wdat[k] = 64'(k + 1); wstb[k] = 8'hFF; end
      axi_write(32'h100, 3, 1'b0);
      axi_read(32'h100, 3, 1);

      // wrap at top of memory
      wdat[0] = 64'hAAAA_0000_AAAA_0001; wdat[1] = 64'hBBBB_0000_BBBB_0002;
      wstb[0] = 8'hFF; wstb[1] = 8'hFF;
      axi_write(32'hFF8, 1, 1'b0);
      axi_read(32'h0, 0, 0);
      axi_read(32'hFF8, 1, 2);

      // concurrent write and read starting the same cycle
      for (int unsigned k = 0; k < 8; k++) begin wdat[k] = {$urandom, $urandom}; wstb[k] = 8'hFF; end
      fork
         axi_write(32'h200, 7, 1'b0);
         axi_read(32'h400, 7, 0);
      join
      axi_read(32'h200, 7, 0);

      // reset in the middle of a 4-beat read, after beat 2
      @(negedge clk);
      araddr = 32'h100; arlen = 8'd3; arvalid = 1'b1;
      @(negedge clk);
      arvalid = 1'b0; rready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b1; rready = 1'b0;
      #1;
      check_eq("mid_rst_rvalid", rvalid, 0);
      check_eq("mid_rst_rlast", rlast, 0);
      check_eq("mid_rst_rdata", rdata, 0);
      check_eq("mid_rst_arready", arready, 0);
      @(negedge clk);
      check_eq("mid_rst_rvalid2", rvalid, 0);
      rst = 1'b0;
      #1;
      check_eq("rel_arready", arready, 1);
      check_eq("rel_awready", awready, 1);
      check_eq("rel_rvalid", rvalid, 0);
      axi_read(32'h100, 3, 0);
      axi_read(32'h10, 0, 2);

      // random traffic; address upper bits and low bits must be ignored
      for (int unsigned t = 0; t < 40; t++) begin
         logic [31:0] a;
         int unsigned len;
         a = $urandom;
         len = ($urandom_range(0, 5) == 0) ? $urandom_range(8, 20) : $urandom_range(0, 7);
         if ($urandom_range(0, 1) == 1) begin
            for (int unsigned k = 0; k <= len; k++) begin
               wdat[k] = {$urandom, $urandom};
               wstb[k] = 8'($urandom);
            end
            axi_write(a, len, 1'b1);
         end else begin
            axi_read(a, len, $urandom_range(0, 2));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/axi_mem_slave.md
AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 9, word-address width (depth 2^ADDR_BITS words of 64 bits; 4 KiB default).
REQ-002 SHALL have port S_AXI_ACLK  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port S_AXI_ARESET  input  1  reset; synchronous, active-high.
REQ-004 SHALL have write-address ports: S_AXI_AWADDR in 32, S_AXI_AWLEN in 8, S_AXI_AWSIZE in 3, S_AXI_AWBURST in 2, S_AXI_AWPROT in 3, S_AXI_AWVALID in 1, S_AXI_AWREADY out 1.
REQ-005 SHALL have write-data ports: S_AXI_WDATA in 64, S_AXI_WSTRB in 8, S_AXI_WLAST in 1, S_AXI_WVALID in 1, S_AXI_WREADY out 1.
REQ-006 SHALL have write-response ports: S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1.
REQ-007 SHALL have read-address ports: S_AXI_ARADDR in 32, S_AXI_ARLEN in 8, S_AXI_ARSIZE in 3, S_AXI_ARBURST in 2, S_AXI_ARPROT in 3, S_AXI_ARVALID in 1, S_AXI_ARREADY out 1.
REQ-008 SHALL have read-data ports: S_AXI_RDATA out 64, S_AXI_RRESP out 2, S_AXI_RLAST out 1, S_AXI_RVALID out 1, S_AXI_RREADY in 1.

Function
REQ-009 SHALL treat every burst as INCR, 8-byte beats; AWSIZE/ARSIZE, AWBURST/ARBURST, AWPROT/ARPROT ignored.
REQ-010 SHALL form word index = ADDR[ADDR_BITS+2:3]; ADDR[2:0] and bits above ignored; index +1 per beat, wrapping modulo 2^ADDR_BITS.
REQ-011 SHALL drive BRESP and RRESP constant 2'b00 (OKAY).
REQ-012 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP.
REQ-013 W_IDLE: AWREADY=1, WREADY=0; AW handshake latches index, moves to W_DATA next cycle.
REQ-014 W_DATA: AWREADY=0, WREADY=1; each W handshake writes byte lane i of the word iff WSTRB[i]=1, then increments index.
REQ-015 W burst SHALL end on the beat with WLAST=1 regardless of AWLEN; next cycle W_RESP with BVALID=1.
REQ-016 W_RESP: BVALID held until BREADY=1; handshake returns to W_IDLE (AWREADY=1 next cycle).
REQ-017 W data presented while in W_IDLE SHALL NOT be accepted (WREADY=0).
REQ-018 Read FSM SHALL have states R_IDLE, R_DATA, independent of write FSM.
REQ-019 R_IDLE: ARREADY=1, RVALID=0; AR handshake in cycle N latches index and beat count ARLEN+1; RVALID=1 with first-beat data in cycle N+1 (R_DATA).
REQ-020 R_DATA: RDATA, RLAST SHALL be registered and held stable while RVALID=1 and RREADY=0.
REQ-021 Each R handshake SHALL present the next beat the following cycle with no bubble; RLAST=1 exactly on beat ARLEN+1.
REQ-022 R handshake with RLAST=1 SHALL return to R_IDLE; RVALID=0, ARREADY=1 next cycle.
REQ-023 ARLEN=0 SHALL produce a single beat with RLAST=1.
REQ-024 Same-cycle write beat and read fetch of same word: read returns pre-write data; write visible to any later fetch.
REQ-025 Read and write bursts SHALL proceed concurrently with no mutual stalls.

Reset
REQ-026 While S_AXI_ARESET=1: AWREADY=0, WREADY=0, BVALID=0, ARREADY=0, RVALID=0, RLAST=0, RDATA=0; both FSMs to idle.
REQ-027 First cycle after reset deasserts: AWREADY=1, ARREADY=1.
REQ-028 Reset mid-burst SHALL abandon the burst (no BVALID, no further R beats); memory contents SHALL NOT be cleared; completed writes retained.

Verification
REQ-029 Single write AWADDR=0x10, WDATA=0x1122334455667788, WSTRB=0xFF, WLAST=1 -> BVALID one cycle after W handshake; read ARADDR=0x10, ARLEN=0 -> RDATA=0x1122334455667788, RLAST=1, RVALID one cycle after AR.
REQ-030 Byte strobe: word 0x20 preloaded 0xFFFF_FFFF_FFFF_FFFF, write WDATA=0, WSTRB=0x0C -> readback 0xFFFF_FFFF_0000_FFFF.
REQ-031 Burst AWLEN=3 at 0x100 with data 1,2,3,4; read ARLEN=3 with RREADY toggled 1,0,1,0,... -> beats 1,2,3,4 in order, data held during stalls, RLAST only on beat 4.
REQ-032 Wrap: ADDR_BITS=9, write 2 beats at 0xFF8 (data A,B) -> B stored at word 0; read ARADDR=0x0 returns B.
REQ-033 Concurrent: 8-beat write to 0x200 and 8-beat read of 0x400 started same cycle -> both complete with no stall cycles; read data unaffected.
REQ-034 Reset asserted mid 4-beat read after beat 2 -> RVALID=0 while reset high, ARREADY=1 after release, earlier written data still readable.
